// File: rtl/pixel_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_array_sequencer
// Description : Runs one measurement frame per trigger: integrator reset,
//               integrate, hold, then an N_CH-channel ADC scan.  Each frame
//               is emitted as a framed byte packet on a valid/ready byte
//               interface feeding the UART transmitter.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module pixel_array_sequencer #(
  parameter int N_CH        = 4,
  parameter int ADC_W       = 12,
  parameter int T_RESET     = 2000,
  parameter int T_HOLD      = 2000,
  parameter int T_INT_SHORT = 5000000,
  parameter int T_INT_LONG  = 50000000,
  parameter int ADC_TIMEOUT = 1000,
  parameter int CNT_W       = 32
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start_n,
  input  logic             cont_mode,
  input  logic             stop_n,
  input  logic             t_sel,
  output logic             reset_iv_n,
  output logic             hold_iv_n,
  output logic             d_out,
  output logic             adc_start,
  output logic [2:0]       adc_ch,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             busy,
  output logic [7:0]       frame_cnt,
  output logic             err_timeout
);

  // A phase of length T ends when the timer reaches T-1; a zero length
  // behaves like a length of one.
  localparam logic [CNT_W-1:0] C_RESET_LAST     = (T_RESET     > 1) ? CNT_W'(T_RESET - 1)     : '0;
  localparam logic [CNT_W-1:0] C_HOLD_LAST      = (T_HOLD      > 1) ? CNT_W'(T_HOLD - 1)      : '0;
  localparam logic [CNT_W-1:0] C_INT_SHORT_LAST = (T_INT_SHORT > 1) ? CNT_W'(T_INT_SHORT - 1) : '0;
  localparam logic [CNT_W-1:0] C_INT_LONG_LAST  = (T_INT_LONG  > 1) ? CNT_W'(T_INT_LONG - 1)  : '0;
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST   = (ADC_TIMEOUT > 1) ? CNT_W'(ADC_TIMEOUT - 1) : '0;
  localparam logic [2:0]       C_LAST_CH        = 3'(N_CH - 1);
  // Packet is sync byte, status byte, then two bytes per channel.
  localparam logic [4:0]       C_LAST_BYTE      = 5'(2 * N_CH + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET_IV  = 3'd1,
    S_INTEGRATE = 3'd2,
    S_HOLD      = 3'd3,
    S_CONV_REQ  = 3'd4,
    S_CONV_WAIT = 3'd5,
    S_TX        = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_t_int_last;
  logic [2:0]       r_ch;
  logic [4:0]       r_byte_idx;
  logic             r_stop_req;
  logic [ADC_W-1:0] r_sample [N_CH];

  logic r_start_meta, r_start_sync, r_start_dly;
  logic r_stop_meta,  r_stop_sync;

  logic        w_start;
  logic [4:0]  w_next_idx;
  logic [7:0]  w_next_byte;
  logic [15:0] w_sample_ext [N_CH];

  // Two-flop synchronizers for the front-panel buttons plus a delay stage
  // for falling-edge detection on start.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_start_meta <= 1'b1;
      r_start_sync <= 1'b1;
      r_start_dly  <= 1'b1;
      r_stop_meta  <= 1'b1;
      r_stop_sync  <= 1'b1;
    end else begin
      r_start_meta <= start_n;
      r_start_sync <= r_start_meta;
      r_start_dly  <= r_start_sync;
      r_stop_meta  <= stop_n;
      r_stop_sync  <= r_stop_meta;
    end
  end

  assign w_start = r_start_dly & ~r_start_sync;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ext
      assign w_sample_ext[gi] = 16'(r_sample[gi]);
    end
  endgenerate

  // Byte that follows the one currently on tx_data.
  always_comb begin
    w_next_idx  = r_byte_idx + 5'd1;
    w_next_byte = 8'h00;
    if (w_next_idx == 5'd1) begin
      w_next_byte = {frame_cnt[6:0], err_timeout};
    end
    for (int k = 0; k < N_CH; k++) begin
      if (w_next_idx == 5'(2 + 2 * k)) begin
        w_next_byte = w_sample_ext[k][15:8];
      end
      if (w_next_idx == 5'(3 + 2 * k)) begin
        w_next_byte = w_sample_ext[k][7:0];
      end
    end
  end

  // Frame sequencer; outputs are registered and updated on state entry.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_t_int_last <= C_INT_SHORT_LAST;
      r_ch         <= 3'd0;
      r_byte_idx   <= 5'd0;
      r_stop_req   <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        r_sample[k] <= '0;
      end
      reset_iv_n   <= 1'b1;
      hold_iv_n    <= 1'b1;
      d_out        <= 1'b0;
      adc_start    <= 1'b0;
      adc_ch       <= 3'd0;
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      busy         <= 1'b0;
      frame_cnt    <= 8'd0;
      err_timeout  <= 1'b0;
    end else begin
      r_timer   <= r_timer + CNT_W'(1);
      adc_start <= 1'b0;
      if (!r_stop_sync) begin
        r_stop_req <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_t_int_last <= t_sel ? C_INT_LONG_LAST : C_INT_SHORT_LAST;
            err_timeout  <= 1'b0;
            r_state      <= S_RESET_IV;
            r_timer      <= '0;
            reset_iv_n   <= 1'b0;
            d_out        <= 1'b1;
            busy         <= 1'b1;
          end
        end

        S_RESET_IV: begin
          if (r_timer == C_RESET_LAST) begin
            r_state    <= S_INTEGRATE;
            r_timer    <= '0;
            reset_iv_n <= 1'b1;
            d_out      <= 1'b0;
          end
        end

        S_INTEGRATE: begin
          if (r_timer == r_t_int_last) begin
            r_state   <= S_HOLD;
            r_timer   <= '0;
            hold_iv_n <= 1'b0;
            d_out     <= 1'b1;
          end
        end

        S_HOLD: begin
          if (r_timer == C_HOLD_LAST) begin
            r_ch      <= 3'd0;
            adc_ch    <= 3'd0;
            adc_start <= 1'b1;
            r_state   <= S_CONV_REQ;
            r_timer   <= '0;
          end
        end

        S_CONV_REQ: begin
          r_state <= S_CONV_WAIT;
          r_timer <= '0;
        end

        S_CONV_WAIT: begin
          if (adc_valid || (r_timer == C_TIMEOUT_LAST)) begin
            // A missing conversion is recorded as all-ones and flagged.
            for (int k = 0; k < N_CH; k++) begin
              if (r_ch == 3'(k)) begin
                r_sample[k] <= adc_valid ? adc_data : '1;
              end
            end
            if (!adc_valid) begin
              err_timeout <= 1'b1;
            end
            r_timer <= '0;
            if (r_ch == C_LAST_CH) begin
              hold_iv_n  <= 1'b1;
              d_out      <= 1'b0;
              r_byte_idx <= 5'd0;
              tx_valid   <= 1'b1;
              tx_data    <= 8'hA5;
              r_state    <= S_TX;
            end else begin
              r_ch      <= r_ch + 3'd1;
              adc_ch    <= r_ch + 3'd1;
              adc_start <= 1'b1;
              r_state   <= S_CONV_REQ;
            end
          end
        end

        S_TX: begin
          if (tx_ready) begin
            if (r_byte_idx == C_LAST_BYTE) begin
              tx_valid <= 1'b0;
              r_state  <= S_DONE;
              r_timer  <= '0;
            end else begin
              r_byte_idx <= w_next_idx;
              tx_data    <= w_next_byte;
            end
          end
        end

        S_DONE: begin
          frame_cnt <= frame_cnt + 8'd1;
          r_timer   <= '0;
          if (cont_mode && !r_stop_req) begin
            r_t_int_last <= t_sel ? C_INT_LONG_LAST : C_INT_SHORT_LAST;
            r_state      <= S_RESET_IV;
            reset_iv_n   <= 1'b0;
            d_out        <= 1'b1;
          end else begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            r_stop_req <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_array_sequencer
// Description : Directed bench for pixel_array_sequencer with an ADC
//               responder and a byte scoreboard on the UART side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_array_sequencer;

  localparam int N_CH        = 4;
  localparam int ADC_W       = 12;
  localparam int T_RESET     = 5;
  localparam int T_HOLD      = 4;
  localparam int T_INT_SHORT = 10;
  localparam int T_INT_LONG  = 30;
  localparam int ADC_TIMEOUT = 20;
  localparam int CNT_W       = 32;

  logic             clk_in    = 1'b0;
  logic             reset     = 1'b0;
  logic             start_n   = 1'b1;
  logic             cont_mode = 1'b0;
  logic             stop_n    = 1'b1;
  logic             t_sel     = 1'b0;
  logic             adc_valid = 1'b0;
  logic [ADC_W-1:0] adc_data  = '0;
  logic             tx_ready  = 1'b1;
  logic             reset_iv_n, hold_iv_n, d_out, adc_start;
  logic [2:0]       adc_ch;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             busy;
  logic [7:0]       frame_cnt;
  logic             err_timeout;

  pixel_array_sequencer #(
    .N_CH(N_CH), .ADC_W(ADC_W), .T_RESET(T_RESET), .T_HOLD(T_HOLD),
    .T_INT_SHORT(T_INT_SHORT), .T_INT_LONG(T_INT_LONG),
    .ADC_TIMEOUT(ADC_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in), .reset(reset), .start_n(start_n), .cont_mode(cont_mode),
    .stop_n(stop_n), .t_sel(t_sel), .reset_iv_n(reset_iv_n),
    .hold_iv_n(hold_iv_n), .d_out(d_out), .adc_start(adc_start),
    .adc_ch(adc_ch), .adc_valid(adc_valid), .adc_data(adc_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .frame_cnt(frame_cnt), .err_timeout(err_timeout)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]       exp_q [$];
  logic [ADC_W-1:0] data_tab [N_CH] = '{12'h123, 12'h456, 12'h789, 12'hABC};
  int               drop_ch    = -1;
  bit               stall_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected packet for one frame; drop marks the channel that times out.
  task automatic push_frame(input int fc, input bit err, input int drop);
    logic [7:0]  f;
    logic [15:0] v;
    f = 8'(fc);
    exp_q.push_back(8'hA5);
    exp_q.push_back({f[6:0], err});
    for (int k = 0; k < N_CH; k++) begin
      v = (k == drop) ? 16'h0FFF : 16'(data_tab[k]);
      exp_q.push_back(v[15:8]);
      exp_q.push_back(v[7:0]);
    end
  endtask

  // ADC model: answers each request 5 clocks later unless the channel is dropped.
  int pend_cnt   = 0;
  int pend_ch    = 0;
  int exp_ch     = 0;
  bit prev_start = 1'b0;
  always @(negedge clk_in) begin
    if (!reset) begin
      pend_cnt   = 0;
      exp_ch     = 0;
      prev_start = 1'b0;
      adc_valid  = 1'b0;
    end else begin
      adc_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          adc_valid = 1'b1;
          adc_data  = data_tab[pend_ch];
        end
      end
      if (adc_start) begin
        check("adc_start_width", 32'(prev_start), 0);
        check("adc_ch", 32'(adc_ch), exp_ch);
        exp_ch = (exp_ch + 1) % N_CH;
        if (int'(adc_ch) != drop_ch) begin
          pend_cnt = 5;
          pend_ch  = int'(adc_ch);
        end
      end
      prev_start = adc_start;
    end
  end

  // UART sink: optional 10-clock stall per byte, scoreboard pop on acceptance.
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         wait_cnt  = 0;
  always @(negedge clk_in) begin
    if (!reset) begin
      prev_hold = 1'b0;
      wait_cnt  = 0;
    end else if (tx_valid) begin
      if (prev_hold) check("tx_stable", 32'(tx_data), 32'(prev_data));
      if (stall_mode && wait_cnt < 10) begin
        tx_ready = 1'b0;
        wait_cnt++;
      end else begin
        tx_ready = 1'b1;
        wait_cnt = 0;
        if (exp_q.size() == 0) check("tx_unexpected", 32'(tx_valid), 0);
        else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      prev_hold = !tx_ready;
      prev_data = tx_data;
    end else begin
      tx_ready  = !stall_mode;
      prev_hold = 1'b0;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_reset_iv_n"}, 32'(reset_iv_n), 1);
    check({tag, "_hold_iv_n"}, 32'(hold_iv_n), 1);
    check({tag, "_d_out"}, 32'(d_out), 0);
    check({tag, "_adc_start"}, 32'(adc_start), 0);
    check({tag, "_adc_ch"}, 32'(adc_ch), 0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk_in);
    start_n = 1'b0;
    repeat (2) @(negedge clk_in);
    start_n = 1'b1;
  endtask

  // Measures phase lengths and the TX burst of one frame already triggered.
  task automatic measure_frame(input int exp_int, input bit toggle);
    int n;
    n = 0;
    while (reset_iv_n && n < 20) begin n++; @(negedge clk_in); end
    check("reset_iv_seen", 32'(reset_iv_n), 0);
    n = 0;
    while (!reset_iv_n && n < 1000) begin n++; @(negedge clk_in); end
    check("reset_iv_len", n, T_RESET);
    n = 0;
    while (hold_iv_n && n < 1000) begin
      n++;
      if (toggle && n == 5) t_sel = ~t_sel;
      @(negedge clk_in);
    end
    check("integrate_len", n, exp_int);
    n = 0;
    while (!hold_iv_n && n < 1000) begin n++; @(negedge clk_in); end
    check("hold_release", 32'(hold_iv_n), 1);
    n = 0;
    while (tx_valid && n < 2000) begin n++; @(negedge clk_in); end
    check("tx_burst_len", n, stall_mode ? 11 * (2 + 2 * N_CH) : 2 + 2 * N_CH);
    n = 0;
    while (busy && n < 20) begin n++; @(negedge clk_in); end
    check("busy_clear", 32'(busy), 0);
    check("q_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk_in);
    check_reset_vals("rst_init");
    reset = 1'b1;
    repeat (3) @(negedge clk_in);

    // Single frame, short integration.
    push_frame(0, 1'b0, -1);
    pulse_start();
    measure_frame(T_INT_SHORT, 1'b0);
    check("f1_frame_cnt", 32'(frame_cnt), 1);
    check("f1_err", 32'(err_timeout), 0);

    // Back-pressured frame.
    stall_mode = 1'b1;
    push_frame(1, 1'b0, -1);
    pulse_start();
    measure_frame(T_INT_SHORT, 1'b0);
    check("f2_frame_cnt", 32'(frame_cnt), 2);
    stall_mode = 1'b0;
    tx_ready   = 1'b1;

    // Channel 2 times out.
    drop_ch = 2;
    push_frame(2, 1'b1, 2);
    pulse_start();
    measure_frame(T_INT_SHORT, 1'b0);
    check("to_err", 32'(err_timeout), 1);
    check("to_frame_cnt", 32'(frame_cnt), 3);
    drop_ch = -1;
    push_frame(3, 1'b0, -1);
    pulse_start();
    measure_frame(T_INT_SHORT, 1'b0);
    check("to_err_cleared", 32'(err_timeout), 0);

    // Continuous mode, stop during third frame, start while busy ignored.
    cont_mode = 1'b1;
    push_frame(4, 1'b0, -1);
    push_frame(5, 1'b0, -1);
    push_frame(6, 1'b0, -1);
    pulse_start();
    n = 0;
    while (frame_cnt != 8'd6 && n < 3000) begin n++; @(negedge clk_in); end
    check("cont_two_done", 32'(frame_cnt), 6);
    check("cont_busy", 32'(busy), 1);
    stop_n = 1'b0;
    repeat (3) @(negedge clk_in);
    stop_n = 1'b1;
    pulse_start();
    n = 0;
    while (busy && n < 1000) begin n++; @(negedge clk_in); end
    check("cont_stopped", 32'(busy), 0);
    check("cont_frame_cnt", 32'(frame_cnt), 7);
    repeat (20) @(negedge clk_in);
    check("cont_no_retrigger", 32'(busy), 0);
    check("cont_q_empty", exp_q.size(), 0);
    cont_mode = 1'b0;

    // Integration time is latched per frame.
    t_sel = 1'b1;
    push_frame(7, 1'b0, -1);
    pulse_start();
    measure_frame(T_INT_LONG, 1'b1);
    push_frame(8, 1'b0, -1);
    pulse_start();
    measure_frame(T_INT_SHORT, 1'b0);
    check("tsel_frame_cnt", 32'(frame_cnt), 9);

    // Reset while waiting for a conversion.
    pulse_start();
    n = 0;
    while (!adc_start && n < 200) begin n++; @(negedge clk_in); end
    check("rcw_adc_start", 32'(adc_start), 1);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    #1;
    check_reset_vals("rst_conv");
    @(negedge clk_in);
    reset = 1'b1;
    repeat (3) @(negedge clk_in);

    // Reset in the middle of the packet.
    push_frame(0, 1'b0, -1);
    pulse_start();
    n = 0;
    while (exp_q.size() > 7 && n < 500) begin n++; @(negedge clk_in); end
    check("rtx_in_tx", 32'(tx_valid), 1);
    reset = 1'b0;
    #1;
    check_reset_vals("rst_tx");
    exp_q.delete();
    @(negedge clk_in);
    reset = 1'b1;
    repeat (3) @(negedge clk_in);

    // Normal frame after reset recovery.
    push_frame(0, 1'b0, -1);
    pulse_start();
    measure_frame(T_INT_SHORT, 1'b0);
    check("post_rst_frame_cnt", 32'(frame_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
